adc_avg_filter: RTL



---
 rtl/adc_avg_filter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/adc_avg_filter.sv
// Paces the serial ADC receiver and averages windows of 2^LOG2_N samples.
// Publishes the truncated average and the window min/max with a one-cycle valid pulse.
module adc_avg_filter #(
    parameter int unsigned LOG2_N = 3,
    parameter int unsigned DIV    = 50
) (
    input  logic        clk_adc,
    input  logic        rst_adc,
    input  logic        enable_i,
    input  logic        clear_i,
    input  logic [11:0] sample_i,
    input  logic        band_i,
    output logic        inicio_o,
    output logic [11:0] avg_o,
    output logic [11:0] min_o,
    output logic [11:0] max_o,
    output logic        avg_valid_o,
    output logic        busy_o
);

    localparam int unsigned SW = 12;
    localparam int unsigned AW = SW + LOG2_N;
    localparam int unsigned CW = LOG2_N;
    localparam int unsigned N  = 1 << LOG2_N;
    localparam int unsigned TW = $clog2(DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          inicio_q, inicio_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] run_min_q, run_min_d;
    logic [SW-1:0] run_max_q, run_max_d;
    logic [SW-1:0] hold_avg_q, hold_avg_d;
    logic [SW-1:0] hold_min_q, hold_min_d;
    logic [SW-1:0] hold_max_q, hold_max_d;
    logic [SW-1:0] avg_q, avg_d;
    logic [SW-1:0] min_q, min_d;
    logic [SW-1:0] max_q, max_d;
    logic          valid_q, valid_d;

    logic [AW-1:0] acc_sum;
    logic [SW-1:0] min_nx;
    logic [SW-1:0] max_nx;

    assign acc_sum = acc_q + AW'(sample_i);
    assign min_nx  = (sample_i < run_min_q) ? sample_i : run_min_q;
    assign max_nx  = (sample_i > run_max_q) ? sample_i : run_max_q;

    // Conversion pacing: pulse is registered so it lines up with timer == DIV-1.
    always_comb begin
        timer_d  = '0;
        inicio_d = 1'b0;
        if (enable_i) begin
            timer_d  = (timer_q == TW'(DIV - 1)) ? '0 : timer_q + TW'(1);
            inicio_d = (timer_q == TW'(DIV - 2));
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        run_min_d  = run_min_q;
        run_max_d  = run_max_q;
        hold_avg_d = hold_avg_q;
        hold_min_d = hold_min_q;
        hold_max_d = hold_max_q;
        avg_d      = avg_q;
        min_d      = min_q;
        max_d      = max_q;
        valid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                acc_d     = '0;
                cnt_d     = '0;
                run_min_d = '1;
                run_max_d = '0;
                if (enable_i) state_d = ACC;
            end
            ACC: begin
                if (!enable_i || clear_i) begin
                    acc_d     = '0;
                    cnt_d     = '0;
                    run_min_d = '1;
                    run_max_d = '0;
                    if (!enable_i) state_d = IDLE;
                end else if (band_i) begin
                    if (cnt_q == CW'(N - 1)) begin
                        hold_avg_d = SW'(acc_sum >> LOG2_N);
                        hold_min_d = min_nx;
                        hold_max_d = max_nx;
                        acc_d      = '0;
                        cnt_d      = '0;
                        run_min_d  = '1;
                        run_max_d  = '0;
                        state_d    = OUT;
                    end else begin
                        acc_d     = acc_sum;
                        cnt_d     = cnt_q + CW'(1);
                        run_min_d = min_nx;
                        run_max_d = max_nx;
                    end
                end
            end
            OUT: begin
                avg_d   = hold_avg_q;
                min_d   = hold_min_q;
                max_d   = hold_max_q;
                valid_d = 1'b1;
                // A strobe landing here opens the next window.
                if (band_i) begin
                    acc_d     = AW'(sample_i);
                    cnt_d     = CW'(1);
                    run_min_d = sample_i;
                    run_max_d = sample_i;
                end else begin
                    acc_d     = '0;
                    cnt_d     = '0;
                    run_min_d = '1;
                    run_max_d = '0;
                end
                state_d = enable_i ? ACC : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_adc or posedge rst_adc) begin
        if (rst_adc) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            inicio_q   <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            run_min_q  <= '1;
            run_max_q  <= '0;
            hold_avg_q <= '0;
            hold_min_q <= '0;
            hold_max_q <= '0;
            avg_q      <= '0;
            min_q      <= '0;
            max_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            inicio_q   <= inicio_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            run_min_q  <= run_min_d;
            run_max_q  <= run_max_d;
            hold_avg_q <= hold_avg_d;
            hold_min_q <= hold_min_d;
            hold_max_q <= hold_max_d;
            avg_q      <= avg_d;
            min_q      <= min_d;
            max_q      <= max_d;
            valid_q    <= valid_d;
        end
    end

    assign inicio_o    = inicio_q;
    assign avg_o       = avg_q;
    assign min_o       = min_q;
    assign max_o       = max_q;
    assign avg_valid_o = valid_q;
    assign busy_o      = (state_q != IDLE);

endmodule
